image_selector: RTL and testbench
=================================

# image_selector

Image-index controller sitting directly downstream of the push-button debouncers. It consumes their one-cycle press pulses (next, previous, slideshow-mode toggle) and maintains the index of the image being shown. It commits index changes to the LED panel driver only at frame boundaries, so the panel never tears mid-refresh. Outputs feed the panel driver's image-ROM address generator.

## Interface
Parameters:
- NUM_IMAGES, 4, number of stored images; must be ≥ 2.
- IMG_WORDS, 2048, ROM words per image (64×32 panel).
- AUTO_PERIOD, 25_000_000, slideshow interval in clk cycles (1 s at 25 MHz).
- IDX_W, $clog2(NUM_IMAGES), index width.
- ADDR_W, $clog2(NUM_IMAGES*IMG_WORDS), ROM address width.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- next_pulse  in  1  one-cycle press pulse from debouncer: advance image.
- prev_pulse  in  1  one-cycle press pulse: go back one image.
- mode_pulse  in  1  one-cycle press pulse: toggle auto slideshow.
- frame_done  in  1  one-cycle pulse from panel driver at end of each full frame.
- img_idx  out  IDX_W  index of the image currently displayed.
- img_base  out  ADDR_W  img_idx*IMG_WORDS; changes in the same cycle as img_idx.
- auto_mode  out  1  1 = slideshow active.
- swap  out  1  one-cycle pulse in the cycle img_idx/img_base take a new value.

## Operation
- States: IDLE (no change pending), PENDING (target index held, waiting for frame_done).
- Step request per cycle: step = +1 if next (or auto tick) only; −1 if prev only; 0 if both or neither. Simultaneous next and prev cancel.
- Target arithmetic is modulo NUM_IMAGES:
  - NUM_IMAGES−1 +1 wraps to 0.
  - 0 −1 wraps to NUM_IMAGES−1.
  - Must be correct for non-power-of-two NUM_IMAGES.
- IDLE:
  - step ≠ 0: target = img_idx+step, go to PENDING.
  - frame_done is ignored.
- PENDING:
  - Any further step is applied to target (accumulates, wraps).
  - On frame_done, the target including the same-cycle step is committed:
    - If target ≠ img_idx: img_idx ← target, img_base ← target*IMG_WORDS, swap=1.
    - If target = img_idx (e.g. next then prev): no update, swap stays 0.
    - Either way, return to IDLE.
- Auto mode:
  - mode_pulse toggles auto_mode and clears the timer.
  - While auto_mode=1, the timer counts 0..AUTO_PERIOD−1. At terminal count it generates one internal next tick and restarts at 0.
  - Any manual next/prev clears the timer; that cycle's tick is suppressed.
  - A tick coinciding with prev_pulse does not occur, because the timer is cleared. The manual prev wins.
  - auto_mode=0: timer held at 0.
- Reset, asserted at any time including PENDING:
  - Pending target discarded, state IDLE.
  - img_idx=0, img_base=0, auto_mode=0, swap=0, timer=0.

## Timing
- Press pulse at cycle t in IDLE → PENDING at t+1.
- First frame_done at cycle f ≥ t+1 → img_idx/img_base new at f+1, swap high for cycle f+1 only.
- frame_done in the same cycle as the first pulse (IDLE) is not used; the commit waits for the next frame_done.
- Worst-case visible latency is one frame plus one cycle.
- mode_pulse at t → auto_mode toggles at t+1.
- First auto tick occurs AUTO_PERIOD cycles after the toggle. It then follows normal PENDING/frame_done commit.
- All outputs are registered; no combinational input-to-output paths.

## Structure
- Shared package img_pkg holds:
  - State encoding (IDLE, PENDING).
  - Default NUM_IMAGES, IMG_WORDS and AUTO_PERIOD constants, shared with the panel driver and ROM.
- One sub-module, auto_timer:
  - Ports: clk, rst, enable, clear, tick.
  - Wraps the AUTO_PERIOD counter.
- Index wrap and target logic stay in image_selector.

## Test plan
- Reset then next_pulse at t, frame_done at t+5 → img_idx 0→1 at t+6, img_base=2048, swap high for exactly one cycle.
- From img_idx=3 (NUM_IMAGES=4): next → idx 0. From 0: prev → idx 3. Repeat with NUM_IMAGES=3: 2+1→0 and 0−1→2.
- next_pulse and prev_pulse in the same cycle → no PENDING, no swap. Separately, next at t and prev at t+2 before frame_done → no swap, idx unchanged, state IDLE.
- Three next pulses before one frame_done (idx 0) → single swap to idx 3. A next pulse coinciding with frame_done while PENDING on target 1 → commits idx 2.
- AUTO_PERIOD=10, mode_pulse, frame_done every 4 cycles:
  - Idx advances once per tick, with swap pulses.
  - A manual prev mid-count restarts the 10-cycle interval.
  - A second mode_pulse stops advancing.
- rst asserted while PENDING with target 2 (idx 1) → all outputs 0 immediately. The next frame_done after release produces no swap.

Source files
------------

// File: rtl/img_pkg.sv
// Shared definitions for the image selector, panel driver and image ROM:
// selector state encoding and the default image-store geometry.
package img_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } sel_state_t;

  localparam int unsigned DEF_NUM_IMAGES  = 4;
  localparam int unsigned DEF_IMG_WORDS   = 2048;
  localparam int unsigned DEF_AUTO_PERIOD = 25_000_000;

endpackage

// File: rtl/auto_timer.sv
// Slideshow interval counter: runs 0..PERIOD-1 while enabled and emits a
// one-cycle tick at terminal count unless cleared in that same cycle.
module auto_timer
  import img_pkg::*;
#(
  parameter int unsigned PERIOD = DEF_AUTO_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int unsigned     CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] count;
  logic             at_last;

  assign at_last = (count == LAST);
  // A clear in the terminal cycle swallows the tick so a manual press wins.
  assign tick    = enable && !clear && at_last;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (!enable || clear || at_last) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/image_selector.sv
// Image-index controller: folds next/prev/auto requests into a pending
// target and commits it to the panel only on a frame boundary.
module image_selector
  import img_pkg::*;
#(
  parameter int unsigned NUM_IMAGES  = DEF_NUM_IMAGES,
  parameter int unsigned IMG_WORDS   = DEF_IMG_WORDS,
  parameter int unsigned AUTO_PERIOD = DEF_AUTO_PERIOD,
  parameter int unsigned IDX_W       = $clog2(NUM_IMAGES),
  parameter int unsigned ADDR_W      = $clog2(NUM_IMAGES * IMG_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              next_pulse,
  input  logic              prev_pulse,
  input  logic              mode_pulse,
  input  logic              frame_done,
  output logic [IDX_W-1:0]  img_idx,
  output logic [ADDR_W-1:0] img_base,
  output logic              auto_mode,
  output logic              swap
);

  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_IMAGES - 1);
  localparam logic [ADDR_W-1:0] WORDS    = ADDR_W'(IMG_WORDS);

  sel_state_t       state, state_n;
  logic [IDX_W-1:0] target, target_n;
  logic [IDX_W-1:0] base_idx, stepped;
  logic             tick, inc, dec, commit;

  // Explicit compare-and-wrap keeps the modulo exact for any NUM_IMAGES.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] x);
    return (x == LAST_IDX) ? '0 : x + 1'b1;
  endfunction

  function automatic logic [IDX_W-1:0] wrap_dec(input logic [IDX_W-1:0] x);
    return (x == '0) ? LAST_IDX : x - 1'b1;
  endfunction

  auto_timer #(
    .PERIOD (AUTO_PERIOD)
  ) u_auto_timer (
    .clk    (clk),
    .rst    (rst),
    .enable (auto_mode),
    .clear  (mode_pulse | next_pulse | prev_pulse),
    .tick   (tick)
  );

  // NOTE: every always_comb output gets a default first, so no path
  // through the case can leave a signal unassigned and infer a latch.
  always_comb begin
    inc      = next_pulse | tick;
    dec      = prev_pulse;
    base_idx = (state == IDLE) ? img_idx : target;
    stepped  = base_idx;
    state_n  = state;
    target_n = target;
    commit   = 1'b0;

    if (inc && !dec) begin
      stepped = wrap_inc(base_idx);
    end else if (dec && !inc) begin
      stepped = wrap_dec(base_idx);
    end

    case (state)
      IDLE: begin
        if (inc != dec) begin
          state_n  = PENDING;
          target_n = stepped;
        end
      end
      PENDING: begin
        target_n = stepped;
        if (frame_done) begin
          state_n = IDLE;
          commit  = (stepped != img_idx);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      target <= '0;
    end else begin
      state  <= state_n;
      target <= target_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      img_idx   <= '0;
      img_base  <= '0;
      auto_mode <= 1'b0;
      swap      <= 1'b0;
    end else begin
      auto_mode <= auto_mode ^ mode_pulse;
      swap      <= commit;
      if (commit) begin
        img_idx  <= stepped;
        img_base <= ADDR_W'(stepped) * WORDS;
      end
    end
  end

endmodule

// File: tb/tb_image_selector.sv
// Drives two image_selector builds (4 and 3 images) with shared directed and
// random press/frame stimulus against a per-cycle behavioural model.
module tb_image_selector;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        next_pulse = 1'b0;
  logic        prev_pulse = 1'b0;
  logic        mode_pulse = 1'b0;
  logic        frame_done = 1'b0;
  logic [1:0]  idx0, idx1;
  logic [12:0] base0, base1;
  logic        auto0, auto1, swap0, swap1;

  int checks_total = 0;
  int fail_count   = 0;

  int n_img [2] = '{4, 3};
  int per   [2] = '{10, 7};
  int m_idx [2], m_tgt [2], m_timer [2];
  bit m_pend[2], m_auto[2], m_swap[2];

  always #5 clk = ~clk;

  image_selector #(.NUM_IMAGES(4), .IMG_WORDS(2048), .AUTO_PERIOD(10)) dut4 (
    .clk(clk), .rst(rst), .next_pulse(next_pulse), .prev_pulse(prev_pulse),
    .mode_pulse(mode_pulse), .frame_done(frame_done),
    .img_idx(idx0), .img_base(base0), .auto_mode(auto0), .swap(swap0)
  );

  image_selector #(.NUM_IMAGES(3), .IMG_WORDS(2048), .AUTO_PERIOD(7)) dut3 (
    .clk(clk), .rst(rst), .next_pulse(next_pulse), .prev_pulse(prev_pulse),
    .mode_pulse(mode_pulse), .frame_done(frame_done),
    .img_idx(idx1), .img_base(base1), .auto_mode(auto1), .swap(swap1)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks_total++;
    if (got !== exp) begin
      fail_count++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_idx[k] = 0; m_tgt[k] = 0; m_timer[k] = 0;
      m_pend[k] = 0; m_auto[k] = 0; m_swap[k] = 0;
    end
  endtask

  // Rules applied with plain modular integer arithmetic.
  task automatic model_step(input int k, input bit nx, input bit pv,
                            input bit md, input bit fd);
    bit manual, tck;
    int s;
    manual = nx || pv;
    tck = m_auto[k] && !manual && !md && (m_timer[k] == per[k] - 1);
    if (!m_auto[k] || manual || md || m_timer[k] == per[k] - 1) m_timer[k] = 0;
    else m_timer[k]++;
    s = int'(nx || tck) - int'(pv);
    m_swap[k] = 0;
    if (!m_pend[k]) begin
      if (s != 0) begin
        m_tgt[k]  = (m_idx[k] + s + n_img[k]) % n_img[k];
        m_pend[k] = 1;
      end
    end else begin
      m_tgt[k] = (m_tgt[k] + s + n_img[k]) % n_img[k];
      if (fd) begin
        if (m_tgt[k] != m_idx[k]) begin
          m_idx[k]  = m_tgt[k];
          m_swap[k] = 1;
        end
        m_pend[k] = 0;
      end
    end
    if (md) m_auto[k] = !m_auto[k];
  endtask

  task automatic check_all();
    check("n4_idx",  int'(idx0),  m_idx[0]);
    check("n4_base", int'(base0), m_idx[0] * 2048);
    check("n4_auto", int'(auto0), int'(m_auto[0]));
    check("n4_swap", int'(swap0), int'(m_swap[0]));
    check("n3_idx",  int'(idx1),  m_idx[1]);
    check("n3_base", int'(base1), m_idx[1] * 2048);
    check("n3_auto", int'(auto1), int'(m_auto[1]));
    check("n3_swap", int'(swap1), int'(m_swap[1]));
  endtask

  // Called #1 after a rising edge; returns #1 after the next one.
  task automatic cycle(input bit nx, input bit pv, input bit md, input bit fd);
    next_pulse = nx; prev_pulse = pv; mode_pulse = md; frame_done = fd;
    for (int k = 0; k < 2; k++) model_step(k, nx, pv, md, fd);
    @(posedge clk);
    #1;
    check_all();
    next_pulse = 0; prev_pulse = 0; mode_pulse = 0; frame_done = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_all();
    rst = 1'b0;

    // next at t, frame_done at t+5, swap at t+6 only
    cycle(1, 0, 0, 0);
    repeat (4) cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    check("first_idx",  int'(idx0),  1);
    check("first_base", int'(base0), 2048);
    check("first_swap", int'(swap0), 1);
    cycle(0, 0, 0, 0);
    check("swap_once", int'(swap0), 0);

    // wrap both ways for 4 and 3 images
    do_reset();
    cycle(0, 1, 0, 0); cycle(0, 0, 0, 1);
    check("wrap_dec_n4", int'(idx0), 3);
    check("wrap_dec_n3", int'(idx1), 2);
    cycle(1, 0, 0, 0); cycle(0, 0, 0, 1);
    check("wrap_inc_n4", int'(idx0), 0);
    check("wrap_inc_n3", int'(idx1), 0);

    // simultaneous press cancels; next then prev nets to no swap
    cycle(1, 1, 0, 0); cycle(0, 0, 0, 1);
    check("cancel_swap", int'(swap0), 0);
    cycle(1, 0, 0, 0); cycle(0, 0, 0, 0); cycle(0, 1, 0, 0); cycle(0, 0, 0, 1);
    check("net_zero_swap", int'(swap0), 0);
    check("net_zero_idx",  int'(idx0), 0);

    // three nexts accumulate; next coinciding with frame_done counts
    cycle(1, 0, 0, 0); cycle(1, 0, 0, 0); cycle(1, 0, 0, 0); cycle(0, 0, 0, 1);
    check("accum_idx",  int'(idx0), 3);
    check("accum_swap", int'(swap0), 1);
    do_reset();
    cycle(1, 0, 0, 0); cycle(1, 0, 0, 1);
    check("same_cycle_idx", int'(idx0), 2);

    // slideshow with frame_done every 4 cycles, manual prev, then stop
    do_reset();
    cycle(0, 0, 1, 0);
    check("auto_on", int'(auto0), 1);
    for (int i = 0; i < 45; i++) cycle(0, 0, 0, (i % 4) == 3);
    check("auto_advanced", int'(idx0), 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, (i % 4) == 3);
    cycle(0, 1, 0, 0);
    for (int i = 0; i < 30; i++) cycle(0, 0, 0, (i % 4) == 3);
    cycle(0, 0, 1, 0);
    check("auto_off", int'(auto0), 0);
    for (int i = 0; i < 30; i++) cycle(0, 0, 0, (i % 4) == 3);

    // reset while PENDING (idx 1, target 2)
    do_reset();
    cycle(1, 0, 0, 0); cycle(0, 0, 0, 1);
    cycle(1, 0, 0, 0);
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_idx",  int'(idx0),  0);
    check("rst_base", int'(base0), 0);
    check("rst_swap", int'(swap0), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle(0, 0, 0, 1);
    check("rst_no_swap", int'(swap0), 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0,
              $urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks_total, fail_count);
    $finish;
  end

endmodule
